// File: rtl/call_frame_ctrl.sv
// call_frame_ctrl: CALL/RET register-frame stack that replays a popped frame through the write-back port.
// Optional macro CALL_FRAME_CLK_EN adds the 4-bit clk register to each frame and an R_CLK restore step.
module call_frame_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             init,
    input  logic             call_flag,
    input  logic             ret_flag,
    input  logic             err_clr,
    input  logic [31:0]      r_eax,
    input  logic [31:0]      r_ebx,
    input  logic [31:0]      r_ecx,
    input  logic [31:0]      r_edx,
    input  logic [3:0]       r_clk,
    output logic             wb_flag,
    output logic [7:0]       wb_code,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic             overflow,
    output logic             underflow,
    output logic             protocol_err
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef CALL_FRAME_CLK_EN
    localparam int unsigned FRAME_W = 132;
    typedef enum logic [2:0] {IDLE, R_EAX, R_EBX, R_ECX, R_EDX, R_CLK} state_t;
    logic [FRAME_W-1:0] frame_in;
    assign frame_in = {r_clk, r_edx, r_ecx, r_ebx, r_eax};
`else
    localparam int unsigned FRAME_W = 128;
    typedef enum logic [2:0] {IDLE, R_EAX, R_EBX, R_ECX, R_EDX} state_t;
    logic [FRAME_W-1:0] frame_in;
    logic               unused_clk;
    assign frame_in   = {r_edx, r_ecx, r_ebx, r_eax};
    assign unused_clk = ^r_clk;
`endif

    state_t             state, state_nxt;
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [FRAME_W-1:0] rbuf, src;
    logic [CNT_W-1:0]   count_nxt;
    logic               push, pop;
    logic               ovf_nxt, unf_nxt, perr_nxt;
    logic               wb_flag_nxt;
    logic [7:0]         wb_code_nxt;
    logic [31:0]        wb_data_nxt;

    // Request arbitration, stack bookkeeping and restore sequencing.
    always_comb begin
        state_nxt   = state;
        count_nxt   = frame_count;
        push        = 1'b0;
        pop         = 1'b0;
        ovf_nxt     = overflow & ~err_clr;
        unf_nxt     = underflow & ~err_clr;
        perr_nxt    = protocol_err & ~err_clr;
        wb_flag_nxt = 1'b0;
        wb_code_nxt = 8'h00;
        wb_data_nxt = 32'h0;

        if (state != IDLE) begin
            if (call_flag | ret_flag) perr_nxt = 1'b1;
            unique case (state)
                R_EAX:   state_nxt = R_EBX;
                R_EBX:   state_nxt = R_ECX;
                R_ECX:   state_nxt = R_EDX;
`ifdef CALL_FRAME_CLK_EN
                R_EDX:   state_nxt = R_CLK;
`endif
                default: state_nxt = IDLE;
            endcase
        end else if (call_flag & ret_flag) begin
            perr_nxt = 1'b1;
        end else if (call_flag) begin
            if (frame_count == CNT_W'(DEPTH)) begin
                ovf_nxt = 1'b1;
            end else begin
                push      = 1'b1;
                count_nxt = frame_count + CNT_W'(1);
            end
        end else if (ret_flag) begin
            if (frame_count == CNT_W'(0)) begin
                unf_nxt = 1'b1;
            end else begin
                pop       = 1'b1;
                count_nxt = frame_count - CNT_W'(1);
                state_nxt = R_EAX;
            end
        end

        // On the popping edge the buffer is not loaded yet, so read the slot directly.
        src = pop ? mem[AW'(frame_count - CNT_W'(1))] : rbuf;

        unique case (state_nxt)
            R_EAX: begin wb_flag_nxt = 1'b1; wb_code_nxt = 8'h80; wb_data_nxt = src[31:0];   end
            R_EBX: begin wb_flag_nxt = 1'b1; wb_code_nxt = 8'hA0; wb_data_nxt = src[63:32];  end
            R_ECX: begin wb_flag_nxt = 1'b1; wb_code_nxt = 8'hC0; wb_data_nxt = src[95:64];  end
            R_EDX: begin wb_flag_nxt = 1'b1; wb_code_nxt = 8'hE0; wb_data_nxt = src[127:96]; end
`ifdef CALL_FRAME_CLK_EN
            R_CLK: begin wb_flag_nxt = 1'b1; wb_code_nxt = 8'h22; wb_data_nxt = {28'h0, src[131:128]}; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge init) begin
        if (!init) begin
            state        <= IDLE;
            frame_count  <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            protocol_err <= 1'b0;
            wb_flag      <= 1'b0;
            wb_code      <= 8'h00;
            wb_data      <= 32'h0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_count  <= count_nxt;
            overflow     <= ovf_nxt;
            underflow    <= unf_nxt;
            protocol_err <= perr_nxt;
            wb_flag      <= wb_flag_nxt;
            wb_code      <= wb_code_nxt;
            wb_data      <= wb_data_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

    // Frame storage survives reset; only the count is cleared.
    always_ff @(posedge clock) begin
        if (push) mem[AW'(frame_count)] <= frame_in;
        if (pop)  rbuf <= mem[AW'(frame_count - CNT_W'(1))];
    end
endmodule

// File: tb/tb_call_frame_ctrl.sv
// tb_call_frame_ctrl: randomized scoreboard bench for call_frame_ctrl against a queue-based stack model.
// Honours CALL_FRAME_CLK_EN to expect the extra clk restore write.
module tb_call_frame_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;
`ifdef CALL_FRAME_CLK_EN
    localparam int RN = 5;
`else
    localparam int RN = 4;
`endif

    logic             clock = 1'b0;
    logic             init = 1'b1;
    logic             call_flag = 1'b0, ret_flag = 1'b0, err_clr = 1'b0;
    logic [31:0]      r_eax = '0, r_ebx = '0, r_ecx = '0, r_edx = '0;
    logic [3:0]       r_clk = '0;
    logic             wb_flag, busy, overflow, underflow, protocol_err;
    logic [7:0]       wb_code;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] frame_count;

    call_frame_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .init(init), .call_flag(call_flag), .ret_flag(ret_flag),
        .err_clr(err_clr), .r_eax(r_eax), .r_ebx(r_ebx), .r_ecx(r_ecx), .r_edx(r_edx),
        .r_clk(r_clk), .wb_flag(wb_flag), .wb_code(wb_code), .wb_data(wb_data),
        .busy(busy), .frame_count(frame_count), .overflow(overflow),
        .underflow(underflow), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [7:0] code; logic [31:0] data; } wb_t;
    typedef struct packed { logic [3:0] k; logic [31:0] d, c, b, a; } frame_t;

    wb_t    sb_q[$];
    frame_t stk[$];
    bit     m_ovf, m_unf, m_perr;
    int     total = 0, bad = 0;
    int     run = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write-back must match the head of the scoreboard; busy runs must span a full restore.
    always @(negedge clock) begin
        if (!init) begin
            run = 0;
        end else begin
            if (wb_flag) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: got code %0h data %0h expected none", wb_code, wb_data);
                end else begin
                    wb_t e;
                    e = sb_q.pop_front();
                    check("wb", {24'h0, wb_code, wb_data}, {24'h0, e.code, e.data});
                end
            end else begin
                check("idle_wb", {24'h0, wb_code, wb_data}, 64'h0);
            end
            if (busy) run++;
            else if (run != 0) begin
                check("busy_len", 64'(run), 64'(RN));
                run = 0;
            end
        end
    end

    task automatic check_status(input string nm);
        check({nm, "_count"}, 64'(frame_count), 64'(stk.size()));
        check({nm, "_flags"}, {61'h0, overflow, underflow, protocol_err}, {61'h0, m_ovf, m_unf, m_perr});
    endtask

    // One clock edge with the current requests; applies a pending err_clr to the model.
    task automatic tick();
        bit c;
        c = err_clr;
        @(posedge clock); #1;
        call_flag = 1'b0; ret_flag = 1'b0; err_clr = 1'b0;
        if (c) begin m_ovf = 0; m_unf = 0; m_perr = 0; end
    endtask

    task automatic push_exp(input frame_t f);
        sb_q.push_back('{code: 8'h80, data: f.a});
        sb_q.push_back('{code: 8'hA0, data: f.b});
        sb_q.push_back('{code: 8'hC0, data: f.c});
        sb_q.push_back('{code: 8'hE0, data: f.d});
`ifdef CALL_FRAME_CLK_EN
        sb_q.push_back('{code: 8'h22, data: {28'h0, f.k}});
`endif
    endtask

    task automatic do_call(input logic [31:0] a, b, c, d, input logic [3:0] k);
        r_eax = a; r_ebx = b; r_ecx = c; r_edx = d; r_clk = k;
        call_flag = 1'b1;
        tick();
        if (stk.size() < DEPTH) stk.push_back('{k: k, d: d, c: c, b: b, a: a});
        else m_ovf = 1;
        check_status("call");
    endtask

    task automatic do_call_rand();
        do_call($urandom, $urandom, $urandom, $urandom, 4'($urandom));
    endtask

    // RET; intrude = k asserts a CALL (or RET if intr_ret) at the k-th edge of the restore.
    task automatic do_ret(input int intrude, input bit intr_ret);
        r_eax = $urandom; r_ebx = $urandom; r_ecx = $urandom; r_edx = $urandom; r_clk = 4'($urandom);
        ret_flag = 1'b1;
        tick();
        if (stk.size() > 0) begin
            push_exp(stk.pop_back());
            for (int k = 1; k <= RN; k++) begin
                if (k == intrude) begin
                    if (intr_ret) ret_flag = 1'b1; else call_flag = 1'b1;
                end
                tick();
                if (k == intrude) m_perr = 1;
            end
        end else begin
            m_unf = 1;
        end
        check_status("ret");
    endtask

    task automatic do_both();
        call_flag = 1'b1; ret_flag = 1'b1;
        tick();
        m_perr = 1;
        check_status("both");
    endtask

    task automatic do_idle();
        tick();
        check_status("idle");
    endtask

    // Reset asserted while R_ECX is on the write-back port.
    task automatic reset_mid();
        frame_t f;
        if (stk.size() == 0) do_call_rand();
        ret_flag = 1'b1;
        tick();
        f = stk.pop_back();
        sb_q.push_back('{code: 8'h80, data: f.a});
        sb_q.push_back('{code: 8'hA0, data: f.b});
        sb_q.push_back('{code: 8'hC0, data: f.c});
        @(posedge clock); @(posedge clock); @(negedge clock); #2;
        init = 1'b0;
        #1;
        check("rst_mid_wb_flag", 64'(wb_flag), 64'h0);
        check("rst_mid_busy", 64'(busy), 64'h0);
        check("rst_mid_count", 64'(frame_count), 64'h0);
        check("rst_mid_sb", 64'(sb_q.size()), 64'h0);
        stk.delete(); m_ovf = 0; m_unf = 0; m_perr = 0;
        @(negedge clock); #2;
        init = 1'b1;
        @(posedge clock); #1;
        check_status("post_rst");
    endtask

    initial begin
        #2 init = 1'b0;
        #2;
        check("rst_wb", {31'h0, wb_flag, 24'h0, wb_code}, 64'h0);
        check("rst_wb_data", 64'(wb_data), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check_status("rst");
        @(posedge clock); @(posedge clock); #3;
        init = 1'b1;
        repeat (3) do_idle();

        do_call(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4'h5);
        do_ret(0, 0);

        do_call(32'd1, $urandom, $urandom, $urandom, 4'h1);
        do_call(32'd2, $urandom, $urandom, $urandom, 4'h2);
        do_ret(0, 0);
        do_ret(0, 0);

        repeat (DEPTH + 1) do_call_rand();
        repeat (DEPTH + 1) do_ret(0, 0);
        err_clr = 1'b1;
        do_idle();

        do_call_rand();
        do_call_rand();
        do_ret(2, 0);
        do_both();
        err_clr = 1'b1;
        do_ret(0, 0);
        err_clr = 1'b1;
        do_ret(0, 0);

        reset_mid();

        for (int i = 0; i < 400; i++) begin
            int r;
            r = (((i / 60) % 2) == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(30, 99));
            if ($urandom_range(0, 9) == 0) err_clr = 1'b1;
            if (r < 45)       do_call_rand();
            else if (r < 80)  do_ret(0, 0);
            else if (r < 87)  do_ret(int'($urandom_range(1, RN)), 1'($urandom));
            else if (r < 92)  do_both();
            else if (r < 99)  do_idle();
            else              reset_mid();
        end

        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
